// File: rtl/mode_scheduler_pkg.sv
// Shared encodings for the multi-function clock mode controller:
// state codes, display-mux selects, button indices and small decode helpers.
package mfc_pkg;

   // Controller state, also exported on the mode port
   typedef enum logic [2:0] {
      ST_TIME   = 3'd0,
      ST_CLKSET = 3'd1,
      ST_ALMSET = 3'd2,
      ST_STOPW  = 3'd3,
      ST_RING   = 3'd4,
      ST_GAME   = 3'd5
   } mode_t;

   // Display mux selects
   localparam logic [1:0] DISP_TIME  = 2'd0;
   localparam logic [1:0] DISP_ALARM = 2'd1;
   localparam logic [1:0] DISP_STOPW = 2'd2;
   localparam logic [1:0] DISP_GAME  = 2'd3;

   // Filtered button indices
   localparam int BTN_INC    = 0;
   localparam int BTN_DEC    = 1;
   localparam int BTN_LEFT   = 2;
   localparam int BTN_RIGHT  = 3;
   localparam int BTN_CENTER = 4;
   localparam int BTN_W      = 5;

   // Mode switch vector layout: {clock_set, alarm_set, stop_watch}
   localparam int SW_W     = 3;
   localparam int SW_CLOCK = 2;
   localparam int SW_ALARM = 1;
   localparam int SW_STOPW = 0;

   // Strobes to the set blocks: inc/dec/left/right
   typedef struct packed {
      logic [3:0] clk;
      logic [3:0] alm;
      logic       sw;
      logic       game;
   } btn_route_t;

   // Fixed-priority base mode from the settled switch vector
   function automatic mode_t base_mode(input logic [SW_W-1:0] sw);
      mode_t m;
      if (sw[SW_CLOCK])      m = ST_CLKSET;
      else if (sw[SW_ALARM]) m = ST_ALMSET;
      else if (sw[SW_STOPW]) m = ST_STOPW;
      else                   m = ST_TIME;
      return m;
   endfunction

   // Display source owned by each state
   function automatic logic [1:0] disp_of(input mode_t m);
      logic [1:0] d;
      case (m)
         ST_ALMSET: d = DISP_ALARM;
         ST_STOPW:  d = DISP_STOPW;
         ST_GAME:   d = DISP_GAME;
         default:   d = DISP_TIME;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mode_scheduler_switch_settle.sv
// Debounce-style settle filter: a raw switch vector is accepted only after it
// has been seen unchanged for SETTLE_CYCLES consecutive samples.
module switch_settle
   import mfc_pkg::*;
#(
   parameter int          WIDTH         = SW_W,
   parameter logic [15:0] SETTLE_CYCLES = 16'd50000
) (
   input  logic             MCLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_settled
);

   localparam logic [15:0] CNT_MAX = SETTLE_CYCLES - 16'd1;

   logic [WIDTH-1:0] sw_q;
   logic [15:0]      cnt;
   logic [15:0]      cnt_inc;

   // Counter saturates once the settle window is reached
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 16'd1;

   // Restart the window on any change; publish the vector once it has held
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         sw_q       <= '0;
         cnt        <= '0;
         sw_settled <= '0;
      end else if (sw_raw != sw_q) begin
         sw_q <= sw_raw;
         cnt  <= '0;
      end else begin
         cnt <= cnt_inc;
         if (cnt_inc == CNT_MAX) sw_settled <= sw_q;
      end
   end

endmodule

// File: rtl/mode_scheduler.sv
// Central mode controller: owns display and buttons, grants them to one
// function at a time, and handles alarm ringing / minigame hand-off.
module mode_scheduler
   import mfc_pkg::*;
#(
   parameter logic [15:0] SETTLE_CYCLES = 16'd50000,
   parameter logic [5:0]  RING_TIMEOUT  = 6'd30
) (
   input  logic             MCLK,
   input  logic             RESET,
   input  logic             tick_1s,
   input  logic             sw_clock_set,
   input  logic             sw_alarm_set,
   input  logic             sw_stop_watch,
   input  logic             sw_alarm_on,
   input  logic [BTN_W-1:0] btn_pulse,
   input  logic             alarm_match,
   input  logic             minigame_done,
   output logic [2:0]       mode,
   output logic [1:0]       disp_sel,
   output logic [3:0]       btn_clk,
   output logic [3:0]       btn_alm,
   output logic             btn_sw,
   output logic             btn_game,
   output logic             time_run,
   output logic             ring_active,
   output logic             blink,
   output logic             game_enable,
   output logic             timeout_flag
);

   mode_t          state;
   mode_t          state_nxt;
   mode_t          base;
   logic [SW_W-1:0] sw_settled;
   logic           match_d;
   logic           ring_req;
   logic           ring_expired;
   logic           center;
   logic           btn_any;
   logic           stay;
   logic           in_ring;
   logic [5:0]     ring_cnt;
   btn_route_t     route_nxt;

   switch_settle #(
      .WIDTH         (SW_W),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle (
      .MCLK       (MCLK),
      .RESET      (RESET),
      .sw_raw     ({sw_clock_set, sw_alarm_set, sw_stop_watch}),
      .sw_settled (sw_settled)
   );

   assign base         = base_mode(sw_settled);
   assign ring_req     = alarm_match & ~match_d & sw_alarm_on;
   assign ring_expired = (ring_cnt == RING_TIMEOUT);
   assign center       = btn_pulse[BTN_CENTER];
   assign btn_any      = |btn_pulse;
   assign stay         = (state_nxt == state);
   assign in_ring      = (state == ST_RING) && (state_nxt == ST_RING);
   assign mode         = state;

   // Next-state decode; ring exit priority is alarm-off, then center, then timeout
   always_comb begin
      state_nxt = state;
      case (state)
         ST_TIME, ST_STOPW:    state_nxt = ring_req ? ST_RING : base;
         ST_CLKSET, ST_ALMSET: state_nxt = base;
         ST_RING: begin
            if (!sw_alarm_on)      state_nxt = base;
            else if (center)       state_nxt = ST_GAME;
            else if (ring_expired) state_nxt = base;
         end
         ST_GAME:              if (minigame_done) state_nxt = base;
         default:              state_nxt = ST_TIME;
      endcase
   end

   // Button routing uses the pre-edge state and is suppressed on transitions
   always_comb begin
      route_nxt      = '0;
      if (stay) begin
         case (state)
            ST_CLKSET: route_nxt.clk  = btn_pulse[BTN_RIGHT:BTN_INC];
            ST_ALMSET: route_nxt.alm  = btn_pulse[BTN_RIGHT:BTN_INC];
            ST_STOPW:  route_nxt.sw   = center;
            ST_GAME:   route_nxt.game = center;
            default:   route_nxt      = '0;
         endcase
      end
   end

   // State register with registered per-state outputs and button strobes
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         state       <= ST_TIME;
         disp_sel    <= DISP_TIME;
         time_run    <= 1'b1;
         ring_active <= 1'b0;
         game_enable <= 1'b0;
         btn_clk     <= '0;
         btn_alm     <= '0;
         btn_sw      <= 1'b0;
         btn_game    <= 1'b0;
      end else begin
         state       <= state_nxt;
         disp_sel    <= disp_of(state_nxt);
         time_run    <= (state_nxt != ST_CLKSET);
         ring_active <= (state_nxt == ST_RING);
         game_enable <= (state_nxt == ST_GAME);
         btn_clk     <= route_nxt.clk;
         btn_alm     <= route_nxt.alm;
         btn_sw      <= route_nxt.sw;
         btn_game    <= route_nxt.game;
      end
   end

   // Ring seconds counter and blink phase, both restarted on every ring entry
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         ring_cnt <= '0;
         blink    <= 1'b0;
      end else if (in_ring) begin
         if (tick_1s) begin
            blink <= ~blink;
            if (!ring_expired) ring_cnt <= ring_cnt + 6'd1;
         end
      end else begin
         ring_cnt <= '0;
         blink    <= 1'b0;
      end
   end

   // Alarm edge history and the sticky "ring timed out" indicator
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         match_d      <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         match_d <= alarm_match;
         if (btn_any)
            timeout_flag <= 1'b0;
         else if ((state == ST_RING) && sw_alarm_on && ring_expired)
            timeout_flag <= 1'b1;
      end
   end

endmodule
